pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed per-stage latch banks between decode, execute, memory and writeback. It carries an opaque data payload plus a control field with guaranteed bubble semantics, and adds valid/ready flow control, hazard stall, and flush/squash. An optional 2-entry skid buffer keeps `ready_o` registered. Saturating stall and squash counters feed the performance monitor.

## Interface
- `DATA_W`, 128: payload width (PCs, operands, immediate, register indices); never cleared by a bubble.
- `CTRL_W`, 16: control width (reg_write, mem_read, mem_write, jump, alu_op, ...).
- `CTRL_NOP`, 0: value driven on `ctrl_o` whenever the stage holds no valid entry.
- `SKID`, 1: 1 = 2-entry skid buffer with registered `ready_o`; 0 = single entry with combinational `ready_o`.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk_i` in 1: the single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `valid_i` in 1: upstream entry valid.
- `ready_o` out 1: stage can accept an entry.
- `ctrl_i` in CTRL_W: upstream control field.
- `data_i` in DATA_W: upstream payload.
- `flush_i` in 1: squash all held entries, e.g. on a taken branch.
- `stall_i` in 1: hazard-unit hold of the output side.
- `valid_o` out 1: output entry valid.
- `ready_i` in 1: downstream accepts the entry.
- `ctrl_o` out CTRL_W: output control field.
- `data_o` out DATA_W: output payload.
- `occupancy_o` out 2: entries held, 0..2 (0..1 when SKID=0).
- `stall_cnt_o` out CNT_W: cycles the head entry was held.
- `squash_cnt_o` out CNT_W: flush events that discarded at least one entry.

## Operation
- An input transfer occurs when `valid_i & ready_o`. An output transfer occurs when `valid_o & acc`, where `acc = ready_i & ~stall_i`.
- Storage is a head register, which drives the outputs, and a skid register (SKID=1 only). FIFO order is strict.
- SKID=1 behaviour:
  - Input with the head empty, or with the head dequeuing in the same cycle and the skid empty, loads the head.
  - Input while the head is held loads the skid.
  - When the head dequeues and the skid is full, the skid moves to the head. A simultaneous input then loads the skid.
  - `ready_o` is a register equal to "skid empty after this edge".
- SKID=0 behaviour: `ready_o = ~valid_o | acc` (combinational). Input loads the head.
- Bubble rule: `ctrl_o == CTRL_NOP` whenever `valid_o == 0`. The head control register is written with CTRL_NOP on every edge that leaves the head empty. This guarantees that no write, memory or jump control leaks from an empty stage.
- `data_o` holds its last value while the stage is empty; its content is then undefined for checking.
- `flush_i` is sampled on a clock edge:
  - All entries are invalidated and `ctrl_o` becomes CTRL_NOP.
  - Flush dominates a same-cycle input transfer (the input is discarded) and a same-cycle output transfer.
  - After the edge, `occupancy_o = 0` and `ready_o = 1`.
- `stall_cnt_o` increments on each edge where `valid_o & ~acc & ~flush_i`. It saturates at all-ones.
- `squash_cnt_o` increments on each edge where `flush_i & (occupancy_o != 0)`. It saturates at all-ones.
- `stall_i` never blocks the input side directly. With SKID=1 one further entry may still land in the skid; with SKID=0 `ready_o` drops combinationally.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on `valid_o`/`ctrl_o`/`data_o` after edge N.
- Full throughput is 1 entry per cycle when `acc` is held high.
- Reset (asynchronous assert; deassert synchronised externally) values:
  - `valid_o = 0`, `ctrl_o = CTRL_NOP`, `data_o = 0`.
  - `occupancy_o = 0`, `ready_o = 1`.
  - Both counters 0; the skid is empty.
- Asserting reset mid-transfer discards all entries immediately, without waiting for a clock edge.
- SKID=1 full case: `ready_o` falls on the edge that fills the skid. It rises on the edge that drains the skid or on a flush.
- When `acc` drops, `valid_o`/`ctrl_o`/`data_o` stay stable until the next output transfer.

## Test plan
- Stream, SKID=1:
  - Stimulus: entries data=0x1..0x8 on consecutive cycles, `ready_i=1`, `stall_i=0`.
  - Required: `data_o` shows 0x1..0x8 one cycle later, `valid_o` high for 8 cycles, `stall_cnt_o = 0`.
- Backpressure, SKID=1:
  - Stimulus: send 0xA, 0xB, 0xC with `stall_i` held high from cycle 1.
  - Required: 0xA held at the head, 0xB in the skid, `ready_o = 0`, `occupancy_o = 2`, 0xC not accepted.
  - After releasing the stall, the output order is 0xA, 0xB, 0xC and `stall_cnt_o` equals the held cycles.
- Flush with simultaneous input:
  - Stimulus: occupancy 2 (ctrl 0x0081), then `flush_i = 1` together with `valid_i = 1` and data 0xD.
  - Required: next cycle `valid_o = 0`, `ctrl_o = 0x0000`, `occupancy_o = 0`, `ready_o = 1`, `squash_cnt_o = 1`, and 0xD is never output.
- Bubble:
  - Stimulus: one entry with ctrl 0xFFFF, dequeued at the next edge.
  - Required: the following cycle `valid_o = 0`, `ctrl_o = CTRL_NOP`.
- SKID=0:
  - Stimulus: head full, then drive `ready_i` 0 then 1 within the same cycle.
  - Required: `ready_o` follows `ready_i` in the same cycle, and back-to-back transfers are lossless.
- Reset and counters:
  - Stimulus: assert `rst_i` between clock edges while occupancy is 2.
  - Required: all outputs take their reset values immediately.
  - Required: with CNT_W=4, 20 stalled cycles give `stall_cnt_o = 0xF` (saturated).

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Parametrised pipeline stage register carrying an opaque data
//                payload and a control field with bubble semantics. Provides
//                valid/ready flow control, a hazard stall on the output side,
//                flush/squash of all held entries, an optional 2-entry skid
//                buffer that keeps ready_o registered, and saturating
//                stall/squash performance counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    payload width; the payload is never cleared by a bubble
//    CTRL_W    control field width
//    CTRL_NOP  control value presented whenever the stage is empty
//    SKID      1 = head + skid entry, registered ready_o
//              0 = head entry only, combinational ready_o
//    CNT_W     width of the performance counters
//
//  Ports
//    clk_i         clock, rising edge
//    rst_i         asynchronous active-high reset
//    valid_i       upstream entry valid
//    ready_o       stage can accept an entry
//    ctrl_i        upstream control field
//    data_i        upstream payload
//    flush_i       discard every held entry (and any same-cycle input)
//    stall_i       hazard hold of the output side
//    valid_o       output entry valid
//    ready_i       downstream accepts the entry
//    ctrl_o        output control field (CTRL_NOP when valid_o is low)
//    data_o        output payload (stale while the stage is empty)
//    occupancy_o   number of held entries, 0..2
//    stall_cnt_o   edges on which the head entry was held
//    squash_cnt_o  flushes that discarded at least one entry
// ============================================================================
module pipe_stage_reg #(
    parameter int unsigned          DATA_W   = 128,
    parameter int unsigned          CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]    CTRL_NOP = '0,
    parameter int unsigned          SKID     = 1,
    parameter int unsigned          CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,

    // Upstream side
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [CTRL_W-1:0]   ctrl_i,
    input  logic [DATA_W-1:0]   data_i,

    // Pipeline control
    input  logic                flush_i,
    input  logic                stall_i,

    // Downstream side
    output logic                valid_o,
    input  logic                ready_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic [DATA_W-1:0]   data_o,

    // Status / performance
    output logic [1:0]          occupancy_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    squash_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic                head_valid_q, head_valid_d;
    logic [CTRL_W-1:0]   head_ctrl_q,  head_ctrl_d;
    logic [DATA_W-1:0]   head_data_q,  head_data_d;

    // The skid entry is never filled when SKID=0, so its registers collapse
    // to constants in that configuration.
    logic                skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0]   skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q,  skid_data_d;

    logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]    squash_cnt_q, squash_cnt_d;

    // ------------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------------
    logic w_acc;        // downstream can take the head this cycle
    logic w_deq;        // output transfer
    logic w_in_xfer;    // input transfer
    logic w_ready;      // stage ready, from the selected ready scheme

    assign w_acc     = ready_i & ~stall_i;
    assign w_deq     = head_valid_q & w_acc;
    assign w_in_xfer = valid_i & w_ready;

    // ------------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid_ready
            logic ready_q;

            // Ready means "skid empty after this edge"; a flush empties the
            // skid, so it falls out of skid_valid_d without a special case.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= ~skid_valid_d;
                end
            end

            assign w_ready = ready_q;
        end else begin : g_comb_ready
            // Single entry: accept when empty or when the head leaves now.
            assign w_ready = ~head_valid_q | w_acc;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state for head and skid
    // ------------------------------------------------------------------------
    always_comb begin
        head_valid_d = head_valid_q;
        head_ctrl_d  = head_ctrl_q;
        head_data_d  = head_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            // Flush wins over both a same-cycle input and output transfer.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (w_deq) begin
                if (skid_valid_q) begin
                    // Skid advances to the head; a new input refills the skid.
                    head_valid_d = 1'b1;
                    head_ctrl_d  = skid_ctrl_q;
                    head_data_d  = skid_data_q;
                    skid_valid_d = w_in_xfer;
                    if (w_in_xfer) begin
                        skid_ctrl_d = ctrl_i;
                        skid_data_d = data_i;
                    end
                end else begin
                    head_valid_d = w_in_xfer;
                    if (w_in_xfer) begin
                        head_ctrl_d = ctrl_i;
                        head_data_d = data_i;
                    end
                end
            end else if (!head_valid_q) begin
                // Empty stage: the skid is empty too, so input goes to head.
                if (w_in_xfer) begin
                    head_valid_d = 1'b1;
                    head_ctrl_d  = ctrl_i;
                    head_data_d  = data_i;
                end
            end else if (w_in_xfer) begin
                // Head held: the one extra entry lands in the skid.
                skid_valid_d = 1'b1;
                skid_ctrl_d  = ctrl_i;
                skid_data_d  = data_i;
            end
        end else begin
            if (w_in_xfer) begin
                head_valid_d = 1'b1;
                head_ctrl_d  = ctrl_i;
                head_data_d  = data_i;
            end else if (w_deq) begin
                head_valid_d = 1'b0;
            end
        end

        // Bubble rule: an empty head always carries the NOP control so no
        // write, memory or jump control can leak from an empty stage.
        if (!head_valid_d) begin
            head_ctrl_d = CTRL_NOP;
        end
    end

    // ------------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;

        if (head_valid_q && !w_acc && !flush_i && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + c_CNT_ONE;
        end

        if (flush_i && (head_valid_q || skid_valid_q) && (squash_cnt_q != c_CNT_MAX)) begin
            squash_cnt_d = squash_cnt_q + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_valid_q <= 1'b0;
            head_ctrl_q  <= CTRL_NOP;
            head_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= CTRL_NOP;
            skid_data_q  <= '0;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            head_ctrl_q  <= head_ctrl_d;
            head_data_q  <= head_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready_o      = w_ready;
    assign valid_o      = head_valid_q;
    assign ctrl_o       = head_ctrl_q;
    assign data_o       = head_data_q;
    assign occupancy_o  = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt_o  = stall_cnt_q;
    assign squash_cnt_o = squash_cnt_q;

endmodule
`default_nettype wire
